// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch controller
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    // One queue entry: the fetch address travels with the word it produced.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Redirect targets are word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction-memory port and IF/ID handshake bundle
interface fetch_if;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    // Fetch controller side.
    modport master (
        output im_addr,
        input  im_data,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc
    );

    // Memory / decode side.
    modport slave (
        input  im_addr,
        output im_data,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH x 64-bit fetch queue with combinational head and clear
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fetch_entry_t             din,
    output fetch_entry_t             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // A push into a full queue is only accepted when the head leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    // Next-state for storage, pointers and occupancy; clear overrides everything.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Queue registers; reset empties the queue immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC, fetch FSM and IF/ID queue control; IF_HALT_EN enables zero-word halt
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    fetch_if.master     bus
);
    import fetch_pkg::*;

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          pop;
    logic          flush;
    logic          room;
    logic          fetch_slot;
    logic          halt_hit;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  tail_entry;
    fetch_entry_t  head_entry;
    logic          unused_full;

    assign pop   = bus.if_valid & bus.if_ready;
    // Redirect is ignored before fetching has been started.
    assign flush = redirect & (state_q != ST_IDLE);
    // A slot exists when the queue has space or the head is leaving this cycle.
    assign room  = (fifo_count < QDEPTH_C) | pop;
    // The word on im_data would be taken this cycle unless it is a halt marker.
    assign fetch_slot = (state_q == ST_RUN) & ~redirect & room;

`ifdef IF_HALT_EN
    assign halt_hit = fetch_slot & (bus.im_data == HALT_WORD);
    assign halted   = (state_q == ST_HALT);
`else
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    assign push = fetch_slot & ~halt_hit;

    // FSM next state: start leaves IDLE, a halt marker parks fetch, redirect resumes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_hit) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (redirect) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // PC next value: redirect target wins, otherwise step only when a word is queued.
    always_comb begin
        pc_d = pc_q;
        if (flush) begin
            pc_d = align_pc(redirect_pc);
        end else if (push) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // State and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign tail_entry = {pc_q, bus.im_data};

    fetch_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop & ~flush),
        .clear (flush),
        .din   (tail_entry),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Occupancy comparison above already covers the full condition.
    assign unused_full = fifo_full;

    assign bus.im_addr  = pc_q;
    assign bus.if_valid = ~fifo_empty;
    assign bus.if_instr = fifo_empty ? 32'h0 : head_entry.instr;
    assign bus.if_pc    = fifo_empty ? 32'h0 : head_entry.pc;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller for the pipelined CPU. It owns the program counter, drives the address of the combinational instruction memory, and buffers fetched words in a small queue. The queue feeds the IF/ID boundary through a valid/ready handshake, so decode-stage stalls never lose an instruction. Branch and jump redirects from later stages flush the queue and restart fetch at the target.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- QDEPTH, 2: fetch-queue depth in entries; power of two, ≥2.
- clk  in  1  : the single clock; rising edge.
- rst  in  1  : reset, asynchronous, active-high.
- start  in  1  : leave IDLE and begin fetching; sampled in IDLE only.
- im_addr  out  32  : address to the instruction memory; always equals the PC register.
- im_data  in  32  : instruction word; combinational from im_addr, same cycle.
- redirect  in  1  : taken branch or jump; highest priority.
- redirect_pc  in  32  : target; bits [1:0] forced to 0.
- if_valid  out  1  : queue head valid.
- if_ready  in  1  : decode accepts the head this cycle.
- if_instr  out  32  : head instruction; 0 when the queue is empty.
- if_pc  out  32  : head address; 0 when the queue is empty.
- halted  out  1  : fetch has stopped on a halt marker. Tied 0 unless IF_HALT_EN is defined.

## Operation
- FSM states: IDLE, RUN, HALT.
  - IDLE → RUN when start=1.
  - RUN → HALT on a halt marker (IF_HALT_EN only).
  - HALT → RUN on redirect.
  - Any state → IDLE on rst.
- Reset values: state=IDLE, pc=RESET_PC, queue empty, if_valid=0, if_instr=0, if_pc=0, halted=0.
- pop = if_valid & if_ready.
- push = (state==RUN) & ~redirect & (count<QDEPTH | pop).
  - On push, the entry {pc, im_data} is written to the tail.
  - On push, pc advances to pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Simultaneous push and pop on a full queue is legal; the count is unchanged.
- redirect=1, in any state other than IDLE:
  - The queue is cleared. A pop in the same cycle is discarded; redirect wins.
  - pc ← {redirect_pc[31:2], 2'b00}.
  - No push that cycle.
  - State → RUN.
- redirect in IDLE is ignored.
- pc and the queue hold whenever push=0.
- if_instr and if_pc are stable while if_valid=1 and if_ready=0.

## Timing
- Start latency: start sampled at edge E0; RUN from E0. First push at E1; if_valid=1 after E1.
- Fetch throughput: one instruction per cycle when if_ready is held at 1.
- Redirect latency: redirect sampled at edge N.
  - if_valid=0 during cycle N+1.
  - The target instruction appears at the head after edge N+1.
- Backpressure: with if_ready=0, the queue fills after QDEPTH pushes. im_addr then holds at the next unfetched address.
- Asynchronous rst takes effect immediately. Mid-operation, all in-flight entries are dropped and outputs return to their reset values without waiting for a clock edge.

## Configuration
- Macro: IF_HALT_EN.
- Defined: a fetched word equal to 32'h0000_0000 (the memory's out-of-range default) is a halt marker.
  - The marker is not pushed and pc does not advance.
  - state → HALT and halted=1 from the next edge.
  - Entries already queued still drain normally.
  - halted clears on redirect or rst.
- Undefined: a zero word is an ordinary instruction (sll $0,$0,0 nop) and is pushed like any other. The HALT state is not synthesised and halted is tied 0.

## Structure
- Shared package fetch_pkg:
  - state encodings ST_IDLE, ST_RUN, ST_HALT;
  - PC_STEP=4;
  - HALT_WORD=32'h0000_0000;
  - the width of the queue entry struct {pc, instr}.
- Sub-module fetch_fifo:
  - synchronous FIFO, QDEPTH × 64 bits;
  - ports push, pop, clear, full, empty, count;
  - head data is combinational;
  - same clk and rst.
- fetch_ctrl holds the FSM, the PC, and the push/pop/redirect logic.

## Test plan
- Basic fetch: rst pulse, start=1 for 1 cycle, if_ready=1, program image loaded at 0x00. Required: if_pc 0x00, 0x04, 0x08 with if_instr 0x20100000, 0x20110000, 0x00009024 on consecutive cycles; first if_valid one cycle after start is sampled.
- Backpressure: if_ready=0 for 4 cycles after the first valid. Required: head stays at pc 0x00 / 0x20100000; im_addr freezes at 0x08 with QDEPTH=2. After release, 0x04 then 0x08 delivered in order, with no gaps or duplicates.
- Redirect on a full queue, redirect_pc=0x13, same cycle as if_ready=1. Required: next cycle if_valid=0; following cycle if_pc=0x10, if_instr=0x12280004. The popped head is not repeated.
- Halt: run until pc reaches 0x2c, where the word is zero.
  - With IF_HALT_EN: the last delivered instruction is pc 0x28 / 0x8c100040; halted=1; im_addr holds 0x2c. A subsequent redirect to 0x00 clears halted and refetches 0x20100000.
  - Without IF_HALT_EN: pc 0x2c is delivered with if_instr=0; halted stays 0.
- Reset mid-run: assert rst between edges while the queue holds 2 entries. Required: if_valid=0 and im_addr=RESET_PC immediately; no fetch until the next start.
- Wrap: RESET_PC=32'hFFFF_FFF8 with a memory stub. Required: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 in sequence.
